// File: rtl/acpo_sa_stream_reader.sv
// Read-side master for the ACT+POOL result buffers: walks {bank,row} addresses,
// absorbs the one-cycle BRAM read latency and streams beats out through a small FIFO.
module acpo_sa_stream_reader #(
   parameter int SRAM_DEPTH    = 1024,
   parameter int BAND_WIDTH    = 16,
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 10,
   parameter int FIFO_DEPTH    = 4,
   localparam int RW = $clog2(SRAM_DEPTH),
   localparam int BW = $clog2(BAND_WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic [RW:0]              len_i,
   output logic                     enb_d_sa_o,
   output logic [RW+BW-1:0]         addrb_d_sa_o,
   input  logic [DATA_WIDTH-1:0]    dob_d_sa_i,
   output logic                     enb_a_o,
   output logic [RW+BW-1:0]         addrb_a_o,
   input  logic [ADDRESS_WIDTH-1:0] dob_a_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [DATA_WIDTH-1:0]    out_data_o,
   output logic [ADDRESS_WIDTH-1:0] out_addr_o,
   output logic [BW-1:0]            out_bank_o,
   output logic                     out_last_o,
   output logic                     busy_o,
   output logic                     done_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_WIDTH + ADDRESS_WIDTH + BW + 1;
   localparam logic [BW-1:0] BANK_LAST = BW'(BAND_WIDTH - 1);
   localparam logic [PW+1:0] DEPTH_LIM = (PW+2)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_r;
   logic [RW:0]     len_r;
   logic [RW:0]     row_r;
   logic [BW-1:0]   bank_r;
   logic            enb_r;
   logic            enb_last_r;
   logic [BW-1:0]   addr_bank_r;
   logic [RW-1:0]   addr_row_r;
   logic            pend_r;
   logic            pend_last_r;
   logic [BW-1:0]   pend_bank_r;
   logic [EW-1:0]   mem_r [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [PW:0]     count_r;

   logic            pop_s;
   logic            push_s;
   logic [PW+1:0]   inflight_s;
   logic            issue_s;
   logic            last_pos_s;
   logic            drain_done_s;
   logic [EW-1:0]   head_s;

   // Credit and sequencing decisions; credit counts FIFO entries plus both in-flight stages
   always_comb begin
      pop_s        = (count_r != {(PW+1){1'b0}}) && out_ready_i;
      push_s       = pend_r;
      inflight_s   = (PW+2)'(count_r) + (PW+2)'(pend_r) + (PW+2)'(enb_r);
      issue_s      = (state_r == S_READ) && (inflight_s < DEPTH_LIM);
      last_pos_s   = (bank_r == BANK_LAST) && (row_r == (len_r - (RW+1)'(1)));
      drain_done_s = !enb_r && !pend_r &&
                     ((count_r == {(PW+1){1'b0}}) || ((count_r == (PW+1)'(1)) && pop_s));
      head_s       = mem_r[rd_ptr_r];
   end

   // Job FSM, address walker and the registered BRAM request/pending stages
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= S_IDLE;
         len_r       <= {(RW+1){1'b0}};
         row_r       <= {(RW+1){1'b0}};
         bank_r      <= {BW{1'b0}};
         enb_r       <= 1'b0;
         enb_last_r  <= 1'b0;
         addr_bank_r <= {BW{1'b0}};
         addr_row_r  <= {RW{1'b0}};
         pend_r      <= 1'b0;
         pend_last_r <= 1'b0;
         pend_bank_r <= {BW{1'b0}};
      end else begin
         enb_r       <= 1'b0;
         enb_last_r  <= 1'b0;
         pend_r      <= enb_r;
         pend_last_r <= enb_last_r;
         pend_bank_r <= addr_bank_r;
         case (state_r)
            S_IDLE: begin
               if (start_i) begin
                  len_r   <= len_i;
                  row_r   <= {(RW+1){1'b0}};
                  bank_r  <= {BW{1'b0}};
                  state_r <= (len_i == {(RW+1){1'b0}}) ? S_DONE : S_READ;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_READ: begin
               if (issue_s) begin
                  enb_r       <= 1'b1;
                  enb_last_r  <= last_pos_s;
                  addr_bank_r <= bank_r;
                  addr_row_r  <= row_r[RW-1:0];
                  if (bank_r == BANK_LAST) begin
                     bank_r <= {BW{1'b0}};
                     row_r  <= row_r + (RW+1)'(1);
                  end else begin
                     bank_r <= bank_r + BW'(1);
                  end
                  if (last_pos_s) begin
                     state_r <= S_DRAIN;
                  end else begin
                     state_r <= S_READ;
                  end
               end else begin
                  state_r <= S_READ;
               end
            end
            S_DRAIN: begin
               if (drain_done_s) begin
                  state_r <= S_DONE;
               end else begin
                  state_r <= S_DRAIN;
               end
            end
            S_DONE:  state_r <= S_IDLE;
            default: state_r <= S_IDLE;
         endcase
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; contents are only visible through the valid-gated outputs
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {dob_d_sa_i, dob_a_i, pend_bank_r, pend_last_r};
      end
   end

   // Output stream from the FIFO head, forced to zero when empty
   always_comb begin
      if (count_r != {(PW+1){1'b0}}) begin
         out_valid_o = 1'b1;
         out_data_o  = head_s[EW-1 -: DATA_WIDTH];
         out_addr_o  = head_s[BW+1 +: ADDRESS_WIDTH];
         out_bank_o  = head_s[1 +: BW];
         out_last_o  = head_s[0];
      end else begin
         out_valid_o = 1'b0;
         out_data_o  = {DATA_WIDTH{1'b0}};
         out_addr_o  = {ADDRESS_WIDTH{1'b0}};
         out_bank_o  = {BW{1'b0}};
         out_last_o  = 1'b0;
      end
   end

   assign enb_d_sa_o   = enb_r;
   assign enb_a_o      = enb_r;
   assign addrb_d_sa_o = {addr_bank_r, addr_row_r};
   assign addrb_a_o    = {addr_bank_r, addr_row_r};
   assign busy_o       = (state_r == S_READ) || (state_r == S_DRAIN);
   assign done_o       = (state_r == S_DONE);

endmodule

// File: tb/tb_acpo_sa_stream_reader.sv
// Directed bench for acpo_sa_stream_reader: BRAM model, beat-order scoreboard,
// credit/latency/done timing checks and an abort-by-reset scenario.
module tb_acpo_sa_stream_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic [10:0] len_i = 11'd0;
   logic        enb_d_sa_o;
   logic [13:0] addrb_d_sa_o;
   logic [7:0]  dob_d_sa_i = 8'd0;
   logic        enb_a_o;
   logic [13:0] addrb_a_o;
   logic [9:0]  dob_a_i = 10'd0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [7:0]  out_data_o;
   logic [9:0]  out_addr_o;
   logic [3:0]  out_bank_o;
   logic        out_last_o;
   logic        busy_o;
   logic        done_o;

   acpo_sa_stream_reader dut (
      .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
      .enb_d_sa_o(enb_d_sa_o), .addrb_d_sa_o(addrb_d_sa_o), .dob_d_sa_i(dob_d_sa_i),
      .enb_a_o(enb_a_o), .addrb_a_o(addrb_a_o), .dob_a_i(dob_a_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_addr_o(out_addr_o), .out_bank_o(out_bank_o), .out_last_o(out_last_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int salt = 0;
   int job_id = 0;
   int exp_total = 0;
   logic [3:0] rpat = 4'b1001;

   // monitor-owned state
   int mon_job = 0;
   int beats = 0, issued = 0, popped = 0, done_cnt = 0, done_cyc = -1;
   int first_valid_cyc = -1, first_hs_cyc = -1, last_hs_cyc = -1, first_enb_cyc = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [7:0] dpat(input int b, input int r);
      return 8'((b * 29) + (r * 7) + salt);
   endfunction

   function automatic logic [9:0] apat(input int b, input int r);
      return 10'((b * 61) + (r * 13) + (salt * 3));
   endfunction

   function automatic logic rdy(input int mode);
      if (mode == 0) return 1'b1;
      return rpat[cyc % 4];
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // BRAM model: one-cycle read latency on both buffers
   initial forever begin
      @(posedge clk);
      if (enb_d_sa_o) dob_d_sa_i <= dpat(int'(addrb_d_sa_o[13:10]), int'(addrb_d_sa_o[9:0]));
      if (enb_a_o)    dob_a_i    <= apat(int'(addrb_a_o[13:10]), int'(addrb_a_o[9:0]));
   end

   // Scoreboard and protocol monitor, sampled on the falling edge
   initial forever begin
      @(negedge clk);
      if (job_id != mon_job) begin
         mon_job = job_id;
         beats = 0; issued = 0; popped = 0; done_cnt = 0; done_cyc = -1;
         first_valid_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1; first_enb_cyc = -1;
      end
      if (rst) begin
         if (enb_d_sa_o) begin
            if (first_enb_cyc < 0) first_enb_cyc = cyc;
            check("rd_addr", 32'(addrb_d_sa_o), 32'((issued % 16) * 1024 + issued / 16));
            check("enb_a", 32'(enb_a_o), 32'd1);
            check("addr_a", 32'(addrb_a_o), 32'((issued % 16) * 1024 + issued / 16));
            issued++;
            check("credit", 32'((issued - popped) <= 4), 32'd1);
         end else begin
            check("enb_a_idle", 32'(enb_a_o), 32'd0);
         end
         if (out_valid_o) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            check("beat_range", 32'(beats < exp_total), 32'd1);
            check("bank", 32'(out_bank_o), 32'(beats % 16));
            check("data", 32'(out_data_o), 32'(dpat(beats % 16, beats / 16)));
            check("paddr", 32'(out_addr_o), 32'(apat(beats % 16, beats / 16)));
            check("last", 32'(out_last_o), 32'(beats == exp_total - 1));
            if (out_ready_i) begin
               if (first_hs_cyc < 0) first_hs_cyc = cyc;
               last_hs_cyc = cyc;
               beats++;
               popped++;
            end
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", 32'(busy_o), 32'd0);
         end
      end
   end

   task automatic run_job(input int len, input int rmode, input bit spurious, input int budget);
      int start_cyc;
      int to;
      job_id++;
      salt = salt + 17;
      exp_total = len * 16;
      @(posedge clk); #1;
      start_i = 1'b1;
      len_i = 11'(len);
      out_ready_i = rdy(rmode);
      @(posedge clk); #1;
      start_i = 1'b0;
      start_cyc = cyc;
      out_ready_i = rdy(rmode);
      to = 0;
      while (!done_o && to < budget) begin
         start_i = spurious && (to == 3 || to == 8);
         @(posedge clk); #1;
         out_ready_i = rdy(rmode);
         to++;
      end
      start_i = 1'b0;
      check("job_done", 32'(done_o), 32'd1);
      @(negedge clk); #1;
      check("beats", 32'(beats), 32'(exp_total));
      check("issued", 32'(issued), 32'(exp_total));
      check("done_cnt", 32'(done_cnt), 32'd1);
      if (len > 0) begin
         check("enb_latency", 32'(first_enb_cyc - start_cyc), 32'd1);
         check("valid_latency", 32'(first_valid_cyc - start_cyc), 32'd3);
         check("done_after_last", 32'(done_cyc - last_hs_cyc), 32'd1);
         if (rmode == 0) check("throughput", 32'(last_hs_cyc - first_hs_cyc), 32'(exp_total - 1));
      end else begin
         check("zero_done_cyc", 32'(done_cyc - start_cyc), 32'd0);
         check("zero_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
      end
   endtask

   initial begin
      int to;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_enb", 32'(enb_d_sa_o), 32'd0);
      check("rst_addr", 32'(addrb_d_sa_o), 32'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      run_job(1, 0, 1'b0, 200);      // T1
      run_job(3, 1, 1'b0, 600);      // T2
      run_job(0, 0, 1'b0, 20);       // T3
      run_job(1, 0, 1'b1, 200);      // T4: starts while busy are ignored
      run_job(2, 0, 1'b0, 300);      // T4: start in the cycle after done
      repeat (4) @(posedge clk);
      #1;
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_valid", 32'(out_valid_o), 32'd0);

      // T5: abort a len=4 job by reset while beat 20 is presented
      job_id++;
      salt = salt + 17;
      exp_total = 64;
      @(posedge clk); #1;
      start_i = 1'b1;
      len_i = 11'd4;
      out_ready_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      to = 0;
      while (beats != 19 && to < 200) begin
         @(negedge clk); #1;
         to++;
      end
      check("reach_beat20", 32'(beats), 32'd19);
      rst = 1'b0;
      #1;
      check("abort_valid", 32'(out_valid_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_done", 32'(done_o), 32'd0);
      check("abort_enb_d", 32'(enb_d_sa_o), 32'd0);
      check("abort_enb_a", 32'(enb_a_o), 32'd0);
      check("abort_addr", 32'(addrb_d_sa_o), 32'd0);
      check("abort_data", 32'(out_data_o), 32'd0);
      check("abort_last", 32'(out_last_o), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b1;
      run_job(1, 0, 1'b0, 200);      // restart from {0,0}

      run_job(1024, 0, 1'b0, 20000); // T6

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
